// File: rtl/bcd_sweep_scheduler_pkg.sv
// Shared definitions for the BCD sweep scheduler: field/digit widths,
// sweep FSM states and time-field indices.
package bcd_sweep_scheduler_pkg;

    localparam int FIELD_W = 6;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        COMMIT  = 2'd3
    } state_e;

    localparam int SEC = 0;
    localparam int MIN = 1;
    localparam int HR  = 2;

endpackage

// File: rtl/bcd_sweep_scheduler.sv
// Time-multiplexes one external binary-to-BCD converter over the time fields
// of the selected source and commits all digit pairs of a sweep at once.
module bcd_sweep_scheduler
    import bcd_sweep_scheduler_pkg::*;
#(
    parameter int NUM_FIELDS   = 3,
    parameter int CONV_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          src_sel,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields_a,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields_b,
    output logic [FIELD_W-1:0]            conv_value,
    input  logic [DIGIT_W-1:0]            conv_tens,
    input  logic [DIGIT_W-1:0]            conv_ones,
    output logic [NUM_FIELDS*8-1:0]       digits,
    output logic                          busy,
    output logic                          sweep_done,
    output logic                          overrun
);

    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int CNT_W = $clog2(CONV_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONV_LATENCY - 1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d, idx_next_s;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [FIELD_W-1:0]          src_s     [NUM_FIELDS];
    logic [FIELD_W-1:0]          shadow_q  [NUM_FIELDS];
    logic [FIELD_W-1:0]          shadow_d  [NUM_FIELDS];
    logic [2*DIGIT_W-1:0]        staging_q [NUM_FIELDS];
    logic [2*DIGIT_W-1:0]        staging_d [NUM_FIELDS];
    logic [FIELD_W-1:0]          conv_value_q, conv_value_d;
    logic [NUM_FIELDS*8-1:0]     digits_q, digits_d;
    logic                        busy_q, busy_d;
    logic                        sweep_done_q, sweep_done_d;
    logic                        overrun_q, overrun_d;

    // Unpack the selected source into per-field operands.
    always_comb begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (src_sel) begin
                src_s[i] = fields_b[i*FIELD_W +: FIELD_W];
            end else begin
                src_s[i] = fields_a[i*FIELD_W +: FIELD_W];
            end
        end
    end

    assign idx_next_s = idx_q + IDX_W'(1);

    // Sweep sequencing; field 0 is issued straight from the source on acceptance
    // so its operand appears at the acceptance edge itself.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        staging_d    = staging_q;
        conv_value_d = conv_value_q;
        digits_d     = digits_q;
        sweep_done_d = 1'b0;
        overrun_d    = tick && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (tick) begin
                    shadow_d     = src_s;
                    idx_d        = '0;
                    cnt_d        = '0;
                    conv_value_d = src_s[SEC];
                    state_d      = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                staging_d[idx_q] = {conv_tens, conv_ones};
                if (idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    idx_d        = idx_next_s;
                    conv_value_d = shadow_q[idx_next_s];
                    state_d      = ISSUE;
                end
            end
            COMMIT: begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    digits_d[i*8 +: 8] = staging_q[i];
                end
                sweep_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any sweep without committing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            conv_value_q <= '0;
            digits_q     <= '0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i]  <= '0;
                staging_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            conv_value_q <= conv_value_d;
            digits_q     <= digits_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
            overrun_q    <= overrun_d;
            shadow_q     <= shadow_d;
            staging_q    <= staging_d;
        end
    end

    assign conv_value = conv_value_q;
    assign digits     = digits_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bcd_sweep_scheduler.sv
// Self-checking bench: table-driven sweeps with a digit scoreboard, plus
// overrun, back-to-back, mid-sweep reset and latency-3 sequences.
module tb_bcd_sweep_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0, src_sel = 1'b0;
    logic [17:0] fa = 18'd0, fb = 18'd0;
    logic [5:0]  cv1;
    logic [3:0]  ct1, co1;
    logic [23:0] digits1;
    logic        busy1, done1, ovr1;

    logic        tick3 = 1'b0;
    logic [17:0] fa3 = 18'd0, fb3 = 18'd0;
    logic [5:0]  cv3;
    logic [3:0]  p3_t [3];
    logic [3:0]  p3_o [3];
    logic [23:0] digits3;
    logic        busy3, done3, ovr3;

    int tests = 0, fails = 0;
    int busy_cnt = 0, done_cnt = 0, ovr_cnt = 0;
    logic [23:0] sb [$];

    typedef struct {
        logic        sel;
        logic [17:0] fa;
        logic [17:0] fb;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    bcd_sweep_scheduler #(.NUM_FIELDS(3), .CONV_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .src_sel(src_sel),
        .fields_a(fa), .fields_b(fb), .conv_value(cv1),
        .conv_tens(ct1), .conv_ones(co1), .digits(digits1),
        .busy(busy1), .sweep_done(done1), .overrun(ovr1)
    );

    bcd_sweep_scheduler #(.NUM_FIELDS(3), .CONV_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .tick(tick3), .src_sel(1'b0),
        .fields_a(fa3), .fields_b(fb3), .conv_value(cv3),
        .conv_tens(p3_t[2]), .conv_ones(p3_o[2]), .digits(digits3),
        .busy(busy3), .sweep_done(done3), .overrun(ovr3)
    );

    // Model converters: latency 1 and a 3-stage pipeline.
    always @(posedge clk) begin
        ct1 <= 4'(cv1 / 6'd10);
        co1 <= 4'(cv1 % 6'd10);
        p3_t[0] <= 4'(cv3 / 6'd10);
        p3_o[0] <= 4'(cv3 % 6'd10);
        p3_t[1] <= p3_t[0];
        p3_o[1] <= p3_o[0];
        p3_t[2] <= p3_t[1];
        p3_o[2] <= p3_o[1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] pk(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt <= busy_cnt + int'(busy1);
            done_cnt <= done_cnt + int'(done1);
            ovr_cnt  <= ovr_cnt + int'(ovr1);
            if (done1) begin
                if (sb.size() == 0) check("sb_extra_commit", 32'(done1), 32'd0);
                else check("sb_digits", 32'(digits1), 32'(sb.pop_front()));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [5:0] f0;
        f0 = v.sel ? v.fb[5:0] : v.fa[5:0];
        src_sel = v.sel; fa = v.fa; fb = v.fb; tick = 1'b1;
        sb.push_back(v.exp);
        busy_cnt = 0; done_cnt = 0;
        step();                                   // E0
        tick = 1'b0;
        check("conv_value_e0", 32'(cv1), 32'(f0));
        check("busy_e0", 32'(busy1), 32'd1);
        fa = pk(1, 1, 1); fb = pk(1, 1, 1); src_sel = ~v.sel;
        repeat (6) step();                        // E0+6
        check("done_early", 32'(done1), 32'd0);
        step();                                   // E0+7
        check("digits_commit", 32'(digits1), 32'(v.exp));
        check("sweep_done", 32'(done1), 32'd1);
        check("busy_fall", 32'(busy1), 32'd0);
        step();                                   // E0+8
        check("done_pulse_end", 32'(done1), 32'd0);
        check("busy_cycles", 32'(busy_cnt), 32'd7);
        check("done_cycles", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, pk(12, 34, 56), pk(1, 2, 3),   24'h12_34_56};
        vecs[1] = '{1'b1, pk(12, 34, 56), pk(0, 5, 59),  24'h00_05_59};
        vecs[2] = '{1'b0, pk(0, 0, 0),    pk(5, 5, 5),   24'h00_00_00};
        vecs[3] = '{1'b0, pk(63, 63, 63), pk(0, 0, 0),   24'h63_63_63};
        vecs[4] = '{1'b1, pk(0, 0, 0),    pk(23, 59, 10), 24'h23_59_10};
        vecs[5] = '{1'b0, pk(9, 10, 40),  pk(63, 0, 0),  24'h09_10_40};

        repeat (2) step();
        check("rst_digits", 32'(digits1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_overrun", 32'(ovr1), 32'd0);
        check("rst_conv_value", 32'(cv1), 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Overrun: extra ticks during ISSUE/CAPTURE and during COMMIT.
        src_sel = 1'b0; fa = pk(1, 2, 3); tick = 1'b1; sb.push_back(24'h01_02_03);
        busy_cnt = 0; done_cnt = 0; ovr_cnt = 0;
        step(); tick = 1'b0;                      // E0
        step(); step(); tick = 1'b1;              // E0+2
        step(); tick = 1'b0;                      // E0+3
        check("overrun_mid", 32'(ovr1), 32'd1);
        step();
        check("overrun_clear", 32'(ovr1), 32'd0);
        step(); step(); tick = 1'b1;              // E0+6
        step(); tick = 1'b0;                      // E0+7
        check("overrun_commit", 32'(ovr1), 32'd1);
        check("overrun_done", 32'(done1), 32'd1);
        repeat (9) step();
        check("overrun_no_resweep", 32'(busy1), 32'd0);
        check("overrun_busy_cycles", 32'(busy_cnt), 32'd7);
        check("overrun_done_cycles", 32'(done_cnt), 32'd1);
        check("overrun_pulses", 32'(ovr_cnt), 32'd2);

        // Back-to-back ticks at minimum spacing.
        src_sel = 1'b1; fb = pk(4, 5, 6); tick = 1'b1; sb.push_back(24'h04_05_06);
        busy_cnt = 0; done_cnt = 0; ovr_cnt = 0;
        step(); tick = 1'b0;                      // E0
        repeat (7) step();                        // E0+7
        check("b2b_done1", 32'(done1), 32'd1);
        src_sel = 1'b0; fa = pk(7, 8, 9); tick = 1'b1; sb.push_back(24'h07_08_09);
        step(); tick = 1'b0;                      // E0+8
        check("b2b_busy2", 32'(busy1), 32'd1);
        repeat (7) step();                        // E0+15
        check("b2b_done2", 32'(done1), 32'd1);
        check("b2b_digits2", 32'(digits1), 32'h07_08_09);
        step();
        check("b2b_done_cycles", 32'(done_cnt), 32'd2);
        check("b2b_overrun", 32'(ovr_cnt), 32'd0);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'd14);

        // Reset mid-sweep with prior digits 11_22_33.
        run_vec('{1'b0, pk(11, 22, 33), pk(0, 0, 0), 24'h11_22_33});
        fa = pk(44, 55, 6); tick = 1'b1;
        step(); tick = 1'b0;                      // E0
        repeat (4) step();                        // E0+4
        #2 reset = 1'b1;
        #1;
        check("mid_rst_digits", 32'(digits1), 32'd0);
        check("mid_rst_busy", 32'(busy1), 32'd0);
        check("mid_rst_conv", 32'(cv1), 32'd0);
        check("mid_rst_done", 32'(done1), 32'd0);
        step();
        reset = 1'b0; done_cnt = 0;
        repeat (10) step();
        check("mid_rst_no_commit", 32'(done_cnt), 32'd0);
        check("mid_rst_digits_hold", 32'(digits1), 32'd0);

        // Latency-3 instance with maximum field values.
        fa3 = pk(63, 63, 63); tick3 = 1'b1;
        step(); tick3 = 1'b0;                     // E0
        repeat (12) step();                       // E0+12
        check("lat3_before", 32'(digits3), 32'd0);
        check("lat3_busy", 32'(busy3), 32'd1);
        step();                                   // E0+13
        check("lat3_digits", 32'(digits3), 32'h63_63_63);
        check("lat3_done", 32'(done3), 32'd1);
        check("lat3_busy_fall", 32'(busy3), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
